// File: rtl/cache_req_arbiter.sv
// cache_req_arbiter: round-robin arbiter sharing one cache port between requesters, with a stall watchdog
module cache_req_arbiter #(
  parameter int REQ_COUNT = 4,
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 32,
  parameter int TIMEOUT   = 64
) (
  input  logic                        CLK,
  input  logic                        RST_N,
  input  logic [REQ_COUNT-1:0]        IN_REQ,
  input  logic [REQ_COUNT-1:0]        IN_WE,
  input  logic [REQ_COUNT*ADDR_W-1:0] IN_ADDR,
  input  logic [REQ_COUNT*DATA_W-1:0] IN_WDATA,
  output logic [REQ_COUNT-1:0]        OUT_ACK,
  output logic [REQ_COUNT-1:0]        OUT_ERR,
  output logic [REQ_COUNT-1:0]        OUT_GRANT,
  output logic [DATA_W-1:0]           OUT_RDATA,
  output logic                        CACHE_REQ,
  output logic                        CACHE_WE,
  output logic [ADDR_W-1:0]           CACHE_ADDR,
  output logic [DATA_W-1:0]           CACHE_WDATA,
  input  logic                        CACHE_ACK,
  input  logic [DATA_W-1:0]           CACHE_RDATA
);
  localparam int PW = $clog2(REQ_COUNT);
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]           state_q, state_d;
  logic [PW-1:0]        ptr_q, ptr_d;
  logic [PW-1:0]        gidx_q, gidx_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [REQ_COUNT-1:0] grant_q, grant_d;
  logic [REQ_COUNT-1:0] ack_q, ack_d;
  logic [REQ_COUNT-1:0] err_q, err_d;
  logic [DATA_W-1:0]    rdata_q, rdata_d;
  logic                 req_q, req_d;
  logic                 we_q, we_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [DATA_W-1:0]    wdata_q, wdata_d;
  logic [PW-1:0]        win;
  logic                 any;
  logic                 tmo;

  // Scan from PTR downwards in reverse so the last hit is the first set bit in priority order
  always_comb begin
    win = '0;
    any = 1'b0;
    for (int i = REQ_COUNT - 1; i >= 0; i--) begin
      if (IN_REQ[(int'(ptr_q) + i) % REQ_COUNT]) begin
        win = PW'((int'(ptr_q) + i) % REQ_COUNT);
        any = 1'b1;
      end
    end
  end

  assign tmo = (TIMEOUT != 0) && (cnt_q == CW'(TIMEOUT - 1));

  // Next-state: grant in IDLE, complete or abort in BUSY, clear everything leaving DONE
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gidx_d  = gidx_q;
    cnt_d   = cnt_q;
    grant_d = grant_q;
    ack_d   = ack_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    if (state_q == IDLE && any) begin
      state_d = BUSY;
      gidx_d  = win;
      cnt_d   = '0;
      grant_d = {{(REQ_COUNT-1){1'b0}}, 1'b1} << win;
      req_d   = 1'b1;
      we_d    = IN_WE[win];
      addr_d  = IN_ADDR[int'(win)*ADDR_W +: ADDR_W];
      wdata_d = IN_WDATA[int'(win)*DATA_W +: DATA_W];
    end else if (state_q == BUSY && (CACHE_ACK || tmo)) begin
      state_d = DONE;
      req_d   = 1'b0;
      ack_d   = grant_q;
      err_d   = CACHE_ACK ? '0 : grant_q;
      rdata_d = CACHE_ACK ? CACHE_RDATA : '0;
      ptr_d   = (gidx_q == PW'(REQ_COUNT - 1)) ? '0 : gidx_q + 1'b1;
    end else if (state_q == BUSY) begin
      cnt_d   = (TIMEOUT != 0) ? cnt_q + 1'b1 : cnt_q;
    end else if (state_q == DONE) begin
      state_d = IDLE;
      grant_d = '0;
      ack_d   = '0;
      err_d   = '0;
      rdata_d = '0;
      we_d    = 1'b0;
      addr_d  = '0;
      wdata_d = '0;
    end
  end

  // State registers; reset drops any in-flight transaction immediately
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      gidx_q  <= '0;
      cnt_q   <= '0;
      grant_q <= '0;
      ack_q   <= '0;
      err_q   <= '0;
      rdata_q <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gidx_q  <= gidx_d;
      cnt_q   <= cnt_d;
      grant_q <= grant_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  assign OUT_ACK     = ack_q;
  assign OUT_ERR     = err_q;
  assign OUT_GRANT   = grant_q;
  assign OUT_RDATA   = rdata_q;
  assign CACHE_REQ   = req_q;
  assign CACHE_WE    = we_q;
  assign CACHE_ADDR  = addr_q;
  assign CACHE_WDATA = wdata_q;
endmodule

// File: tb/tb_cache_req_arbiter.sv
// tb_cache_req_arbiter: scoreboard bench for the round-robin cache request arbiter
module tb_cache_req_arbiter;
  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic [3:0]  IN_REQ = '0;
  logic [3:0]  IN_WE = '0;
  logic [63:0] IN_ADDR = '0;
  logic [127:0] IN_WDATA = '0;
  logic [3:0]  OUT_ACK, OUT_ERR, OUT_GRANT;
  logic [31:0] OUT_RDATA;
  logic        CACHE_REQ, CACHE_WE;
  logic [15:0] CACHE_ADDR;
  logic [31:0] CACHE_WDATA;
  logic        CACHE_ACK = 1'b0;
  logic [31:0] CACHE_RDATA = '0;

  cache_req_arbiter #(.REQ_COUNT(4), .ADDR_W(16), .DATA_W(32), .TIMEOUT(4)) dut (
    .CLK(CLK), .RST_N(RST_N), .IN_REQ(IN_REQ), .IN_WE(IN_WE), .IN_ADDR(IN_ADDR),
    .IN_WDATA(IN_WDATA), .OUT_ACK(OUT_ACK), .OUT_ERR(OUT_ERR), .OUT_GRANT(OUT_GRANT),
    .OUT_RDATA(OUT_RDATA), .CACHE_REQ(CACHE_REQ), .CACHE_WE(CACHE_WE),
    .CACHE_ADDR(CACHE_ADDR), .CACHE_WDATA(CACHE_WDATA), .CACHE_ACK(CACHE_ACK),
    .CACHE_RDATA(CACHE_RDATA)
  );

  always #5 CLK = ~CLK;

  typedef struct { logic [3:0] g; logic we; logic [15:0] addr; logic [31:0] wd; } req_t;
  typedef struct { logic [3:0] g; logic err; logic [31:0] rd; } ack_t;
  req_t exp_req[$];
  ack_t exp_ack[$];
  int tests = 0;
  int fails = 0;
  logic [15:0] a_c [4] = '{16'h0A00, 16'h0B11, 16'h1A2B, 16'h0D33};
  logic [31:0] w_c [4] = '{32'h1111_0000, 32'h2222_0001, 32'h3333_0002, 32'h4444_0003};
  logic [3:0]  we_c = 4'b1010;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic req_t mk_req(input int i);
    req_t r;
    r.g = 4'b0001 << i;
    r.we = we_c[i];
    r.addr = a_c[i];
    r.wd = w_c[i];
    return r;
  endfunction

  function automatic ack_t mk_ack(input int i, input logic err, input logic [31:0] rd);
    ack_t a;
    a.g = 4'b0001 << i;
    a.err = err;
    a.rd = rd;
    return a;
  endfunction

  // Monitor: compare each new cache request and each completion against the queues
  initial begin
    logic prev_req;
    logic [3:0] prev_ack;
    req_t r;
    ack_t a;
    prev_req = 1'b0;
    prev_ack = '0;
    forever begin
      @(negedge CLK);
      if (CACHE_REQ && !prev_req) begin
        if (exp_req.size() == 0) chk("unexpected_req", 64'(CACHE_REQ), 64'(0));
        else begin
          r = exp_req.pop_front();
          chk("req_grant", 64'(OUT_GRANT), 64'(r.g));
          chk("req_we", 64'(CACHE_WE), 64'(r.we));
          chk("req_addr", 64'(CACHE_ADDR), 64'(r.addr));
          chk("req_wdata", 64'(CACHE_WDATA), 64'(r.wd));
        end
      end
      if (OUT_ACK != 0) begin
        if (exp_ack.size() == 0) chk("unexpected_ack", 64'(OUT_ACK), 64'(0));
        else begin
          a = exp_ack.pop_front();
          chk("ack_vec", 64'(OUT_ACK), 64'(a.g));
          chk("ack_err", 64'(OUT_ERR), a.err ? 64'(a.g) : 64'(0));
          chk("ack_rdata", 64'(OUT_RDATA), 64'(a.rd));
          chk("ack_grant", 64'(OUT_GRANT), 64'(a.g));
          chk("ack_req_low", 64'(CACHE_REQ), 64'(0));
        end
      end
      if (prev_ack != 0) chk("ack_single_pulse", 64'(OUT_ACK), 64'(0));
      prev_req = CACHE_REQ;
      prev_ack = OUT_ACK;
    end
  end

  task automatic wait_req();
    int n = 0;
    while (CACHE_REQ !== 1'b1 && n < 50) begin
      @(negedge CLK);
      n++;
    end
    chk("req_seen", 64'(CACHE_REQ), 64'(1));
  endtask

  task automatic serve(input int d, input logic [31:0] rd);
    wait_req();
    repeat (d - 1) @(negedge CLK);
    CACHE_ACK = 1'b1;
    CACHE_RDATA = rd;
    @(negedge CLK);
    CACHE_ACK = 1'b0;
    CACHE_RDATA = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 4; i++) begin
      IN_ADDR[i*16 +: 16] = a_c[i];
      IN_WDATA[i*32 +: 32] = w_c[i];
    end
    IN_WE = we_c;
    #1;
    chk("rst_req", 64'(CACHE_REQ), 64'(0));
    chk("rst_grant", 64'(OUT_GRANT), 64'(0));
    chk("rst_ack", 64'({OUT_ACK, OUT_ERR}), 64'(0));
    chk("rst_rdata", 64'(OUT_RDATA), 64'(0));
    #11 RST_N = 1'b1;
    @(negedge CLK);
    // single read from requester 2
    exp_req.push_back(mk_req(2));
    exp_ack.push_back(mk_ack(2, 1'b0, 32'hDEADBEEF));
    IN_REQ = 4'b0100;
    serve(3, 32'hDEADBEEF);
    IN_REQ = '0;
    @(negedge CLK);
    chk("idle_after_done", 64'({OUT_ACK, OUT_ERR, OUT_GRANT, CACHE_REQ}), 64'(0));
    chk("idle_rdata", 64'(OUT_RDATA), 64'(0));
    // stray cache ack in IDLE is ignored
    CACHE_ACK = 1'b1;
    CACHE_RDATA = 32'hFFFF_FFFF;
    @(negedge CLK);
    CACHE_ACK = 1'b0;
    CACHE_RDATA = '0;
    chk("idle_ack_ignored", 64'({OUT_ACK, OUT_GRANT, CACHE_REQ}), 64'(0));
    chk("idle_ack_rdata", 64'(OUT_RDATA), 64'(0));
    // PTR=3: requesters 0 and 1 wrap around to 0 first
    exp_req.push_back(mk_req(0));
    exp_req.push_back(mk_req(1));
    exp_ack.push_back(mk_ack(0, 1'b0, 32'h0000_A0A0));
    exp_ack.push_back(mk_ack(1, 1'b0, 32'h0000_B1B1));
    IN_REQ = 4'b0011;
    serve(2, 32'h0000_A0A0);
    serve(2, 32'h0000_B1B1);
    IN_REQ = '0;
    repeat (2) @(negedge CLK);
    RST_N = 1'b0;
    @(negedge CLK);
    RST_N = 1'b1;
    @(negedge CLK);
    // all requesters held: order 0,1,2,3,0
    for (int n = 0; n < 5; n++) begin
      exp_req.push_back(mk_req(n % 4));
      exp_ack.push_back(mk_ack(n % 4, 1'b0, 32'h5000_0000 + 32'(n)));
    end
    IN_REQ = 4'b1111;
    for (int n = 0; n < 5; n++) serve(2, 32'h5000_0000 + 32'(n));
    IN_REQ = '0;
    repeat (2) @(negedge CLK);
    chk("rr_quiet", 64'({OUT_GRANT, CACHE_REQ}), 64'(0));
    // timeout: no cache ack
    exp_req.push_back(mk_req(1));
    exp_ack.push_back(mk_ack(1, 1'b1, 32'h0));
    IN_REQ = 4'b0010;
    wait_req();
    begin
      int n = 0;
      while (OUT_ACK == 0 && n < 50) begin
        @(negedge CLK);
        n++;
      end
      chk("timeout_latency", 64'(n), 64'(4));
    end
    IN_REQ = '0;
    @(negedge CLK);
    chk("timeout_idle", 64'({OUT_ACK, OUT_ERR, OUT_GRANT, CACHE_REQ}), 64'(0));
    // ack on the 4th busy edge wins over timeout
    exp_req.push_back(mk_req(1));
    exp_ack.push_back(mk_ack(1, 1'b0, 32'hCAFE_F00D));
    IN_REQ = 4'b0010;
    serve(4, 32'hCAFE_F00D);
    IN_REQ = '0;
    repeat (2) @(negedge CLK);
    // async reset mid-BUSY, then re-grant of requester 0
    exp_req.push_back(mk_req(0));
    exp_req.push_back(mk_req(0));
    IN_REQ = 4'b0001;
    wait_req();
    #2 RST_N = 1'b0;
    #1;
    chk("async_rst_req", 64'(CACHE_REQ), 64'(0));
    chk("async_rst_grant", 64'(OUT_GRANT), 64'(0));
    @(negedge CLK);
    RST_N = 1'b1;
    @(negedge CLK);
    chk("regrant_req", 64'(CACHE_REQ), 64'(1));
    chk("regrant_grant", 64'(OUT_GRANT), 64'(4'b0001));
    exp_ack.push_back(mk_ack(0, 1'b0, 32'h1234_5678));
    serve(2, 32'h1234_5678);
    IN_REQ = '0;
    repeat (3) @(negedge CLK);
    chk("req_queue_drained", 64'(exp_req.size()), 64'(0));
    chk("ack_queue_drained", 64'(exp_ack.size()), 64'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/cache_req_arbiter.md
Name: cache_req_arbiter

Overview:
- Round-robin arbiter that shares the single cache access port between REQ_COUNT requesters (e.g. instruction fetch, data load/store, refill).
- Sits in front of the cache lookup datapath, where tag matches are OR-reduced into a hit.
- Latches the winner's address and write data and drives one cache transaction at a time.
- Returns the ACK/RDATA to the winner, with a watchdog that aborts stalled transactions.

Parameters:
- REQ_COUNT, 4, number of requesters (≥2).
- ADDR_W, 16, address width per requester.
- DATA_W, 32, data width.
- TIMEOUT, 64, BUSY cycles without CACHE_ACK before abort; 0 disables the watchdog.

Ports:
- CLK  in  1  system clock; all state changes on the rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- IN_REQ  in  REQ_COUNT  request; bit i = requester i.
- IN_WE  in  REQ_COUNT  write enable; bit i = requester i.
- IN_ADDR  in  REQ_COUNT*ADDR_W  addresses; requester i at [i*ADDR_W +: ADDR_W].
- IN_WDATA  in  REQ_COUNT*DATA_W  write data; requester i at [i*DATA_W +: DATA_W].
- OUT_ACK  out  REQ_COUNT  one-cycle completion pulse to the owner.
- OUT_ERR  out  REQ_COUNT  one-cycle timeout pulse to the owner, coincident with OUT_ACK.
- OUT_GRANT  out  REQ_COUNT  one-hot current owner; all-zero when idle.
- OUT_RDATA  out  DATA_W  read data, valid while OUT_ACK is high.
- CACHE_REQ  out  1  transaction request to the cache.
- CACHE_WE  out  1  latched write enable.
- CACHE_ADDR  out  ADDR_W  latched address.
- CACHE_WDATA  out  DATA_W  latched write data.
- CACHE_ACK  in  1  cache completion.
- CACHE_RDATA  in  DATA_W  cache read data, valid with CACHE_ACK.

Behaviour:
- Reset (async, immediate):
  - All outputs 0.
  - State IDLE, priority pointer PTR=0, watchdog counter 0.
  - A transaction in flight is dropped; CACHE_REQ falls without waiting for the clock.
- All outputs are registered; there are no combinational input-to-output paths.
- States: IDLE, BUSY, DONE.
- IDLE:
  - any = OR of IN_REQ.
  - If any=1 at edge k: the winner g is the first set bit scanning PTR, PTR+1, …, wrapping modulo REQ_COUNT.
  - At edge k: latch IN_ADDR/IN_WE/IN_WDATA of g into the CACHE_* outputs, set CACHE_REQ=1, OUT_GRANT=1<<g, clear the counter, go to BUSY.
  - Request-to-CACHE_REQ latency: 1 edge.
- BUSY:
  - CACHE_REQ and the CACHE_* fields are held stable.
  - Changes on IN_* (including IN_REQ[g] dropping) are ignored. Requesters must hold IN_REQ until OUT_ACK.
  - CACHE_ACK=1 at edge m:
    - CACHE_REQ=0; OUT_ACK[g]=1; OUT_RDATA=CACHE_RDATA (also captured on writes).
    - PTR=(g+1) mod REQ_COUNT; go to DONE.
  - No CACHE_ACK and TIMEOUT≠0:
    - The counter increments each BUSY edge.
    - On the TIMEOUT-th BUSY edge without ACK: CACHE_REQ=0; OUT_ACK[g]=1, OUT_ERR[g]=1; OUT_RDATA=0; PTR advances as above; go to DONE.
  - ACK and timeout on the same edge: ACK wins, OUT_ERR stays 0.
  - Counter width is ceil(log2(TIMEOUT+1)); it never wraps.
- DONE:
  - Exactly one cycle; OUT_GRANT still shows g.
  - Next edge: OUT_ACK=OUT_ERR=OUT_GRANT=0, go to IDLE.
  - IN_REQ is not sampled in DONE.
  - Earliest next grant is edge m+2. Back-to-back transaction spacing is at least 3 cycles.
- Fairness:
  - A requester that keeps IN_REQ high after OUT_ACK is re-arbitrated in IDLE with the lowest priority.
  - Any pending requester is granted within REQ_COUNT transactions.
- CACHE_ACK in IDLE or DONE is ignored; no outputs change.
- At most one OUT_GRANT/OUT_ACK bit is set at any time.

Test Plan:
1. Reset, then IN_REQ=4'b0100, IN_ADDR[2]=16'h1A2B, IN_WE[2]=0 at edge 1; CACHE_ACK at edge 4 with RDATA=32'hDEADBEEF.
   -> CACHE_REQ=1, CACHE_ADDR=16'h1A2B, GRANT=4'b0100 after edge 1; ACK=4'b0100, RDATA=32'hDEADBEEF after edge 4; all zero after edge 5; PTR=3.
2. IN_REQ=4'b1111 held continuously; cache ACKs 2 cycles after each CACHE_REQ.
   -> grant order 0,1,2,3,0; each ACK a single-cycle pulse.
3. PTR=3 (after serving 2), IN_REQ=4'b0011.
   -> requester 0 granted (wrap-around), then requester 1.
4. TIMEOUT=4, requester 1 requests, CACHE_ACK never arrives.
   -> after the 4th BUSY edge: ACK=ERR=4'b0010, CACHE_REQ=0, RDATA=0; IDLE one cycle later.
5. TIMEOUT=4, CACHE_ACK arrives exactly on the 4th BUSY edge.
   -> ACK=4'b0010, ERR=0.
6. Assert RST_N=0 asynchronously mid-BUSY with IN_REQ=4'b0001 still high.
   -> CACHE_REQ and GRANT drop before the next edge. After release, requester 0 is re-granted 1 edge later with PTR=0.
